matrix_scan_ctrl: RTL and testbench
===================================

// Module: matrix_scan_ctrl
// PURPOSE
//  Row-scan sequencer for the RGB LED matrix: drives columnFiller via fill_en/filled.
//  Latches each shifted row, selects it on row_addr and controls oe_n through settle/dwell.
//  Shifts row N+1 while row N is lit (overlapped fill/display); signals frame boundaries.
// PARAMETERS
//  NUM_ROWS       16    rows scanned per frame (>=2); ADDR_W = $clog2(NUM_ROWS)
//  DWELL_CYCLES   1024  clk cycles each row is displayed (>=1)
//  LAT_CYCLES     2     width of lat pulse in clk cycles (>=1)
//  SETTLE_CYCLES  4     blanked cycles after latch before display (>=1)
// PORTS
//  clk         in   1       system clock
//  rst         in   1       asynchronous, active-high reset
//  run         in   1       level; start/continue scanning
//  filled      in   1       columnFiller: current row fully shifted (level)
//  brightness  in   8       global duty, used only with BRIGHTNESS_EN
//  fill_en     out  1       enable to columnFiller: shift next row
//  lat         out  1       panel latch strobe, active high
//  oe_n        out  1       panel output enable, active low
//  row_addr    out  ADDR_W  row currently displayed
//  frame_done  out  1       1-cycle pulse at end of last row's dwell
//  busy        out  1       high in every state except IDLE
// BEHAVIOUR
//  Reset (async, rst=1): state=IDLE, row_addr=0, fill_row=0, fill_en=0, lat=0,
//   oe_n=1, frame_done=0, busy=0, filled_seen=0, timer=0. All outputs registered.
//  filled qualified: accepted only when fill_en was high the previous cycle (fill_en_q).
//  States:
//  IDLE:    oe_n=1. run=1 -> FILL with fill_en=1.
//  FILL:    fill_en=1; qualified filled -> BLANK, fill_en=0 same edge.
//  BLANK:   1 cycle, oe_n=1, fill_en=0 -> LATCH.
//  LATCH:   lat=1 for LAT_CYCLES. Entry edge: row_addr<=fill_row,
//           fill_row<=(fill_row==NUM_ROWS-1)?0:fill_row+1. Then SETTLE.
//  SETTLE:  SETTLE_CYCLES, lat=0, oe_n=1 -> DISPLAY; fill_en=1, filled_seen=0, timer=0.
//  DISPLAY: timer counts 0..DWELL_CYCLES-1; oe_n=0 while timer<DWELL_CYCLES.
//           fill_en=1 until qualified filled, then fill_en=0, filled_seen=1.
//           At dwell end: filled_seen|qualified filled -> run ? BLANK : IDLE;
//           otherwise STALL: stay, oe_n=1, timer held, wait for filled.
//  frame_done=1 one cycle on DISPLAY exit when row_addr==NUM_ROWS-1.
//  run=0 is honoured only in IDLE and at DISPLAY exit (never mid-shift/latch);
//   exit to IDLE keeps row_addr/fill_row; restart resumes at fill_row.
//  Simultaneous dwell end and filled: no stall; exits same edge.
//  rst mid-operation: immediate return to reset values; lat/fill_en drop asynchronously.
//  timer width $clog2(max(DWELL,LAT,SETTLE)+1); no wrap; reloaded per state entry.
// CONFIGURATION
//  BRIGHTNESS_EN defined: in DISPLAY oe_n=0 only while timer < on_cycles,
//   on_cycles=(brightness*DWELL_CYCLES)>>8 (width 8+timer width); brightness=0 -> dark.
//  Not defined: brightness ignored; oe_n=0 for entire dwell (except STALL).
// STRUCTURE
//  led_matrix_pkg: typedef enum logic [2:0] scan_state_t {IDLE,FILL,BLANK,LATCH,
//   SETTLE,DISPLAY}; localparam BRIGHT_W=8.
//  Sub-module scan_timer: loadable down-counter with done flag, shared by
//   LATCH/SETTLE/DISPLAY phases.
// TESTING (NUM_ROWS=4, DWELL=16, LAT=2, SETTLE=2; columnFiller model asserts filled 5 cycles after fill_en)
//  1 rst=1 then run=1 -> FILL, 1 BLANK, lat=1 2 cycles, row_addr=0, 2 settle, oe_n=0 exactly 16 cycles.
//  2 free run 2 frames -> row_addr 0,1,2,3,0,1,...; frame_done pulses once per 4 dwells; lat never with oe_n=0.
//  3 model filled delay 30 cycles -> oe_n=1 from dwell cycle 16 until filled; no lat before filled.
//  4 filled on final dwell cycle -> BLANK next edge, no stall cycle.
//  5 run=0 during LATCH of row 2 -> row 2 displays 16 cycles, then IDLE, busy=0, oe_n=1; run=1 resumes row 3.
//  6 rst=1 mid-DISPLAY row 1 -> same cycle oe_n=1, fill_en=0, row_addr=0; BRIGHTNESS_EN, brightness=128 -> oe_n low 8 of 16.

Source files
------------

// File: rtl/led_matrix_pkg.sv
// Shared types and helpers for the LED matrix row-scan controller.
package led_matrix_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        FILL    = 3'd1,
        BLANK   = 3'd2,
        LATCH   = 3'd3,
        SETTLE  = 3'd4,
        DISPLAY = 3'd5
    } scan_state_t;

    localparam int BRIGHT_W = 8;

    function automatic int max3(int a, int b, int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/matrix_scan_ctrl_if.sv
// Handshake and panel-drive bundle between the scan controller and its neighbours.
interface matrix_scan_ctrl_if #(
    parameter int ADDR_W = 4
);
    import led_matrix_pkg::*;

    logic                run;
    logic                filled;
    logic [BRIGHT_W-1:0] brightness;
    logic                fill_en;
    logic                lat;
    logic                oe_n;
    logic [ADDR_W-1:0]   row_addr;
    logic                frame_done;
    logic                busy;

    modport master (
        output run, filled, brightness,
        input  fill_en, lat, oe_n, row_addr, frame_done, busy
    );

    modport slave (
        input  run, filled, brightness,
        output fill_en, lat, oe_n, row_addr, frame_done, busy
    );

endinterface

// File: rtl/matrix_scan_ctrl_scan_timer.sv
// Loadable down-counter shared by the latch, settle and dwell phases; done while at zero.
module scan_timer #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         done,
    output logic [W-1:0] count
);
    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done  = (cnt_q == '0);
    assign count = cnt_q;

endmodule

// File: rtl/matrix_scan_ctrl.sv
// Row-scan sequencer: shifts row N+1 through the column filler while row N is lit.
// Optional macro BRIGHTNESS_EN: brightness sets the lit fraction of each dwell.
module matrix_scan_ctrl
    import led_matrix_pkg::*;
#(
    parameter int NUM_ROWS      = 16,
    parameter int DWELL_CYCLES  = 1024,
    parameter int LAT_CYCLES    = 2,
    parameter int SETTLE_CYCLES = 4
) (
    input  logic              clk,
    input  logic              rst,
    matrix_scan_ctrl_if.slave sif
);
    // state   | meaning
    // IDLE    | stopped, panel dark
    // FILL    | first row of a run being shifted, panel dark
    // BLANK   | one dark cycle before the latch strobe
    // LATCH   | lat high, row_addr switched to the freshly shifted row
    // SETTLE  | dark, lat low, row drivers settling
    // DISPLAY | row lit for the dwell while next row shifts; stalls dark if shift is late
    localparam int ADDR_W = $clog2(NUM_ROWS);
    localparam int TW     = $clog2(max3(DWELL_CYCLES, LAT_CYCLES, SETTLE_CYCLES) + 1);

    localparam logic [2:0] S_IDLE    = IDLE;
    localparam logic [2:0] S_FILL    = FILL;
    localparam logic [2:0] S_BLANK   = BLANK;
    localparam logic [2:0] S_LATCH   = LATCH;
    localparam logic [2:0] S_SETTLE  = SETTLE;
    localparam logic [2:0] S_DISPLAY = DISPLAY;

    localparam logic [ADDR_W-1:0] LAST_ROW  = ADDR_W'(NUM_ROWS - 1);
    localparam logic [TW-1:0]     LAT_LD    = TW'(LAT_CYCLES - 1);
    localparam logic [TW-1:0]     SETTLE_LD = TW'(SETTLE_CYCLES - 1);
    localparam logic [TW-1:0]     DWELL_LD  = TW'(DWELL_CYCLES - 1);

    logic [2:0]        state_q, state_d;
    logic [ADDR_W-1:0] row_addr_q, row_addr_d;
    logic [ADDR_W-1:0] fill_row_q, fill_row_d;
    logic              fill_en_q, fill_en_d;
    logic              lat_q, lat_d;
    logic              oe_n_q, oe_n_d;
    logic              frame_done_q, frame_done_d;
    logic              busy_q, busy_d;
    logic              filled_seen_q, filled_seen_d;

    logic              tmr_load;
    logic [TW-1:0]     tmr_val;
    logic              tmr_done;
    logic [TW-1:0]     tmr_count;
    logic              qual_filled;
    logic              lit_entry;
    logic              lit_next;

    scan_timer #(.W(TW)) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .load_val (tmr_val),
        .done     (tmr_done),
        .count    (tmr_count)
    );

    // A stale filled level from the previous shift is ignored unless fill_en was already up.
    assign qual_filled = sif.filled & fill_en_q;

`ifdef BRIGHTNESS_EN
    localparam int ONW = BRIGHT_W + TW;
    logic [ONW-1:0] on_cycles;
    logic [ONW-1:0] elapsed_nx;

    assign on_cycles  = (ONW'(sif.brightness) * ONW'(DWELL_CYCLES)) >> BRIGHT_W;
    assign elapsed_nx = ONW'(DWELL_CYCLES) - ONW'(tmr_count);
    assign lit_entry  = (on_cycles != '0);
    assign lit_next   = (elapsed_nx < on_cycles);
`else
    logic unused_cfg;
    assign unused_cfg = ^{sif.brightness, tmr_count};
    assign lit_entry  = 1'b1;
    assign lit_next   = 1'b1;
`endif

    always_comb begin
        state_d       = state_q;
        row_addr_d    = row_addr_q;
        fill_row_d    = fill_row_q;
        fill_en_d     = fill_en_q;
        lat_d         = 1'b0;
        oe_n_d        = 1'b1;
        frame_done_d  = 1'b0;
        filled_seen_d = filled_seen_q;
        tmr_load      = 1'b0;
        tmr_val       = '0;

        case (state_q)
            S_IDLE: begin
                if (sif.run) begin
                    state_d   = S_FILL;
                    fill_en_d = 1'b1;
                end
            end
            S_FILL: begin
                if (qual_filled) begin
                    state_d   = S_BLANK;
                    fill_en_d = 1'b0;
                end
            end
            S_BLANK: begin
                state_d    = S_LATCH;
                lat_d      = 1'b1;
                row_addr_d = fill_row_q;
                fill_row_d = (fill_row_q == LAST_ROW) ? '0 : fill_row_q + 1'b1;
                tmr_load   = 1'b1;
                tmr_val    = LAT_LD;
            end
            S_LATCH: begin
                if (tmr_done) begin
                    state_d  = S_SETTLE;
                    tmr_load = 1'b1;
                    tmr_val  = SETTLE_LD;
                end else begin
                    lat_d = 1'b1;
                end
            end
            S_SETTLE: begin
                if (tmr_done) begin
                    state_d       = S_DISPLAY;
                    fill_en_d     = 1'b1;
                    filled_seen_d = 1'b0;
                    oe_n_d        = ~lit_entry;
                    tmr_load      = 1'b1;
                    tmr_val       = DWELL_LD;
                end
            end
            S_DISPLAY: begin
                if (qual_filled) begin
                    fill_en_d     = 1'b0;
                    filled_seen_d = 1'b1;
                end
                if (tmr_done) begin
                    // Dwell over: leave only once the next row is in; otherwise hold dark.
                    if (filled_seen_q | qual_filled) begin
                        state_d      = sif.run ? S_BLANK : S_IDLE;
                        fill_en_d    = 1'b0;
                        frame_done_d = (row_addr_q == LAST_ROW);
                    end
                end else begin
                    oe_n_d = ~lit_next;
                end
            end
            default: begin
                state_d   = S_IDLE;
                fill_en_d = 1'b0;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_IDLE;
            row_addr_q    <= '0;
            fill_row_q    <= '0;
            fill_en_q     <= 1'b0;
            lat_q         <= 1'b0;
            oe_n_q        <= 1'b1;
            frame_done_q  <= 1'b0;
            busy_q        <= 1'b0;
            filled_seen_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            row_addr_q    <= row_addr_d;
            fill_row_q    <= fill_row_d;
            fill_en_q     <= fill_en_d;
            lat_q         <= lat_d;
            oe_n_q        <= oe_n_d;
            frame_done_q  <= frame_done_d;
            busy_q        <= busy_d;
            filled_seen_q <= filled_seen_d;
        end
    end

    assign sif.fill_en    = fill_en_q;
    assign sif.lat        = lat_q;
    assign sif.oe_n       = oe_n_q;
    assign sif.row_addr   = row_addr_q;
    assign sif.frame_done = frame_done_q;
    assign sif.busy       = busy_q;

endmodule

// File: tb/tb_matrix_scan_ctrl.sv
// Self-checking bench for matrix_scan_ctrl: random fill delays and brightness against a row-timeline model.
module tb_matrix_scan_ctrl;

    localparam int NR = 4;
    localparam int DW = 16;
    localparam int LC = 2;
    localparam int SC = 2;
    localparam int AW = 2;
    localparam logic [6:0] RST_VEC = 7'b0100000;

    logic clk = 1'b0;
    logic rst;

    matrix_scan_ctrl_if #(.ADDR_W(AW)) sif ();

    matrix_scan_ctrl #(
        .NUM_ROWS      (NR),
        .DWELL_CYCLES  (DW),
        .LAT_CYCLES    (LC),
        .SETTLE_CYCLES (SC)
    ) dut (
        .clk (clk),
        .rst (rst),
        .sif (sif)
    );

    always #5 clk = ~clk;

    // observed outputs: {lat, oe_n, fill_en, busy, frame_done, row_addr}
    logic [6:0] obs;
    assign obs = {sif.lat, sif.oe_n, sif.fill_en, sif.busy, sif.frame_done, sif.row_addr};

    int vectors = 0;
    int errors  = 0;

    // column filler: filled rises fill_delay cycles after fill_en, drops with fill_en
    int fill_delay = 5;
    int fill_cnt   = 0;

    initial begin
        sif.filled = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (sif.fill_en) begin
                fill_cnt++;
                sif.filled = (fill_cnt >= fill_delay);
            end else begin
                fill_cnt   = 0;
                sif.filled = 1'b0;
            end
        end
    end

    // model state: row being displayed, next row to shift, frame_done owed on next cycle
    int m_row  = 0;
    int m_fill = 0;
    bit m_fd   = 1'b0;

    function automatic int on_cyc(int b);
`ifdef BRIGHTNESS_EN
        return (b * DW) / 256;
`else
        return DW + b * 0;
`endif
    endfunction

    // Expected outputs k cycles into a row period that starts with the BLANK cycle.
    function automatic logic [6:0] exp_vec(int k, int d, int row, int prev_row, bit fd, int on);
        int j;
        if (k == 0)       return {1'b0, 1'b1, 1'b0, 1'b1, fd, 2'(prev_row)};
        if (k <= LC)      return {1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 2'(row)};
        if (k <= LC + SC) return {1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 2'(row)};
        j = k - LC - SC - 1;
        return {1'b0, !(j < DW && j < on), (j < d), 1'b1, 1'b0, 2'(row)};
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        sif.run = 1'b0;
        sif.brightness = 8'd0;
        repeat (3) @(negedge clk);
        vectors++;
        if (obs !== RST_VEC) begin
            errors++;
            $display("FAIL reset_vec: got %b want %b", obs, RST_VEC);
        end
        rst = 1'b0;
        repeat (3) @(negedge clk);
        vectors++;
        if (obs !== RST_VEC) begin
            errors++;
            $display("FAIL idle_hold: got %b want %b", obs, RST_VEC);
        end
        m_row = 0; m_fill = 0; m_fd = 1'b0;
    endtask

    task automatic test_start(string name, int d0);
        logic [6:0] exp;
        fill_delay = d0;
        sif.run = 1'b1;
        for (int i = 0; i < d0; i++) begin
            @(negedge clk);
            exp = {1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 2'(m_row)};
            vectors++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL %s fill cycle %0d: got %b want %b", name, i, obs, exp);
            end
        end
    endtask

    task automatic test_scan(string name, int rows, int dlo, int dhi, int stop_row, int rst_row);
        logic [6:0] exp;
        int d, on, row, len;
        for (int r = 0; r < rows; r++) begin
            d = $urandom_range(dhi, dlo);
            fill_delay = d;
            sif.brightness = (r == 0) ? 8'd128 : 8'($urandom_range(255, 0));
            on  = on_cyc(int'(sif.brightness));
            row = m_fill;
            len = 1 + LC + SC + ((d > DW) ? d : DW);
            for (int k = 0; k < len; k++) begin
                @(negedge clk);
                exp = exp_vec(k, d, row, m_row, m_fd, on);
                vectors++;
                if (obs !== exp) begin
                    errors++;
                    $display("FAIL %s row %0d k %0d d %0d: got %b want %b", name, row, k, d, obs, exp);
                end
                if (k == 1 && row == stop_row) sif.run = 1'b0;
                if (row == rst_row && k == LC + SC + 6) begin
                    rst = 1'b1;
                    #1;
                    vectors++;
                    if (obs !== RST_VEC) begin
                        errors++;
                        $display("FAIL %s async_rst: got %b want %b", name, obs, RST_VEC);
                    end
                    m_row = 0; m_fill = 0; m_fd = 1'b0;
                    sif.run = 1'b0;
                    @(negedge clk);
                    rst = 1'b0;
                    @(negedge clk);
                    vectors++;
                    if (obs !== RST_VEC) begin
                        errors++;
                        $display("FAIL %s post_rst_idle: got %b want %b", name, obs, RST_VEC);
                    end
                    return;
                end
            end
            m_fd   = (row == NR - 1);
            m_row  = row;
            m_fill = (row + 1) % NR;
            if (!sif.run) begin
                for (int i = 0; i < 3; i++) begin
                    @(negedge clk);
                    exp = {1'b0, 1'b1, 1'b0, 1'b0, (i == 0) && m_fd, 2'(m_row)};
                    vectors++;
                    if (obs !== exp) begin
                        errors++;
                        $display("FAIL %s idle %0d: got %b want %b", name, i, obs, exp);
                    end
                end
                m_fd = 1'b0;
                return;
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        sif.run = 1'b0;
        sif.brightness = 8'd0;
        test_reset();
        test_start("start", 5);
        test_scan("free_run", 9, 1, DW - 1, -1, -1);
        test_scan("stall30", 1, 30, 30, -1, -1);
        test_scan("edge16", 1, DW, DW, -1, -1);
        test_scan("stall_rand", 3, DW + 1, 40, -1, -1);
        test_scan("run_stop", 1, 1, DW - 1, 2, -1);
        test_start("restart", 5);
        test_scan("resume", 3, 1, DW - 1, -1, 1);
        test_start("post_rst", 3);
        test_scan("recover", 5, 1, DW, -1, -1);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
